stream_demux: RTL
=================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter T_DATA_WIDTH, default 8, data width of every stream.
REQ-002 Parameter T_QOS_WIDTH, default 4, QoS width of every stream.
REQ-003 Parameter STREAM_COUNT, default 2, number of output streams, legal range 2..16.
REQ-004 Local parameter T_ID_WIDTH = $clog2(STREAM_COUNT), not overridable.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 s_data_i  in  T_DATA_WIDTH  input beat data.
REQ-008 s_qos_i  in  T_QOS_WIDTH  input beat QoS, forwarded unchanged.
REQ-009 s_id_i  in  T_ID_WIDTH  destination output index, meaningful on the first beat of a packet.
REQ-010 s_last_i  in  1  final beat of the packet.
REQ-011 s_valid_i  in  1  input beat valid.
REQ-012 s_ready_o  out  1  input beat accepted when s_valid_i && s_ready_o.
REQ-013 m_data_o  out  T_DATA_WIDTH x STREAM_COUNT (unpacked)  per-output data.
REQ-014 m_qos_o  out  T_QOS_WIDTH x STREAM_COUNT (unpacked)  per-output QoS.
REQ-015 m_last_o  out  STREAM_COUNT  per-output last.
REQ-016 m_valid_o  out  STREAM_COUNT  per-output valid.
REQ-017 m_ready_i  in  STREAM_COUNT  per-output ready.
REQ-018 drop_o  out  1  one-cycle pulse when the last beat of a dropped packet is accepted.
REQ-019 id_err_o  out  1  one-cycle pulse when a non-first accepted beat carries s_id_i different from the locked destination.

Function
REQ-020 Each output n has a one-entry register slot (data, qos, last, valid); m_*_o[n] are driven directly from slot n.
REQ-021 Slot n is "free" when m_valid_o[n]==0 or m_ready_i[n]==1, so it is free while it drains in the same cycle.
REQ-022 Controller states: IDLE (no packet open), ROUTE (packet open, destination dst locked), DROP (packet open, destination invalid).
REQ-023 IDLE: when s_id_i < STREAM_COUNT, s_ready_o = free(s_id_i); when s_id_i >= STREAM_COUNT, s_ready_o = 1.
REQ-024 ROUTE: s_ready_o = free(dst), and s_id_i is ignored for routing.
REQ-025 DROP: s_ready_o = 1, and beats are discarded.
REQ-026 Accepted beat in IDLE with legal id: write slot s_id_i, dst <= s_id_i; if s_last_i==0, go to ROUTE, else stay in IDLE.
REQ-027 Accepted beat in IDLE with illegal id: if s_last_i==0, go to DROP; otherwise stay in IDLE and pulse drop_o next cycle.
REQ-028 Accepted beat in ROUTE: write slot dst; s_last_i==1 returns to IDLE.
REQ-029 Accepted beat in DROP with s_last_i==1: return to IDLE and pulse drop_o.
REQ-030 Slot write: on the accepting edge, m_valid_o[n] <= 1 and data/qos/last are loaded, so latency from input handshake to m_valid_o is 1 cycle.
REQ-031 Slot drain: m_valid_o[n] && m_ready_i[n] with no simultaneous write to slot n clears m_valid_o[n]; a simultaneous write and drain leaves valid at 1 with the new contents.
REQ-032 Slot data/qos/last hold their values while m_valid_o[n]==1 && m_ready_i[n]==0.
REQ-033 Every other output slot keeps streaming (draining) independently while a packet is open to dst.
REQ-034 Full throughput: 1 beat/cycle into a single output while m_ready_i[dst] stays 1.
REQ-035 Packet beats are never interleaved across destinations; a new id is sampled only in IDLE.
REQ-036 id_err_o and drop_o are registered, and each pulses for exactly one cycle per event.
REQ-037 When s_valid_i==0, no state or slot-write change occurs; s_ready_o may be 1 while valid is low.

Reset
REQ-038 While rst_n==0: state=IDLE, dst=0, m_valid_o='0, m_last_o='0, m_data_o='0, m_qos_o='0, drop_o=0, id_err_o=0.
REQ-039 Reset asserted mid-packet: the open packet and all slot contents are discarded with no partial delivery after release.
REQ-040 First accept is possible on the first rising edge after rst_n deasserts.

Verification
REQ-041 Single-beat packet: id=1, data=8'hA5, qos=3, last=1, all m_ready_i=1 -> next cycle m_valid_o=2'b10, m_data_o[1]=8'hA5, m_qos_o[1]=3, m_last_o[1]=1; state IDLE.
REQ-042 4-beat packet to id=0 with m_ready_i[0] low for 2 cycles after beat 2 -> s_ready_o low for those 2 cycles, beat 2 held on m_data_o[0], all 4 beats delivered in order, last only on beat 4.
REQ-043 Mid-packet id change: 3-beat packet, first id=0, beat 2 id=1 -> all beats appear on output 0 only, and id_err_o pulses once.
REQ-044 STREAM_COUNT=3, 2-beat packet with id=3 -> s_ready_o=1 for both beats, no m_valid_o asserted, drop_o pulses once after the last beat.
REQ-045 Back-to-back packets to id=0 then id=1, with m_ready_i[0]=0 -> second packet flows to output 1 once the first packet's last beat is stored in slot 0.
REQ-046 rst_n asserted mid 3-beat packet after beat 1 -> all m_valid_o=0 immediately; after release, a new packet with id=1 routes correctly.

Source files
------------

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//
// Routes packets from a single input stream to one of STREAM_COUNT output
// streams. The destination is taken from s_id_i on the first beat of a packet
// and locked until the last beat. Packets addressed to a non-existent output
// are accepted and discarded. Each output has a one-entry register slot, so
// every output drains independently of the others.
//
// Parameters
//   T_DATA_WIDTH  data width of every stream
//   T_QOS_WIDTH   QoS width of every stream (forwarded unchanged)
//   STREAM_COUNT  number of output streams (2..16)
//   T_ID_WIDTH    derived destination index width (not overridable)
//
// Ports
//   clk        clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   s_data_i   input beat data
//   s_qos_i    input beat QoS
//   s_id_i     destination index, sampled on the first beat of a packet
//   s_last_i   final beat of the packet
//   s_valid_i  input beat valid
//   s_ready_o  input beat accepted when s_valid_i && s_ready_o
//   m_data_o   per-output data   (unpacked, one entry per output)
//   m_qos_o    per-output QoS    (unpacked, one entry per output)
//   m_last_o   per-output last
//   m_valid_o  per-output valid
//   m_ready_i  per-output ready
//   drop_o     one-cycle pulse after the last beat of a dropped packet
//   id_err_o   one-cycle pulse after a non-first beat whose id differs from
//              the locked destination
// -----------------------------------------------------------------------------
module stream_demux #(
    parameter  int T_DATA_WIDTH = 8,
    parameter  int T_QOS_WIDTH  = 4,
    parameter  int STREAM_COUNT = 2,
    localparam int T_ID_WIDTH   = $clog2(STREAM_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic [T_QOS_WIDTH-1:0]  s_qos_i,
    input  logic [T_ID_WIDTH-1:0]   s_id_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [STREAM_COUNT],
    output logic [T_QOS_WIDTH-1:0]  m_qos_o  [STREAM_COUNT],
    output logic [STREAM_COUNT-1:0] m_last_o,
    output logic [STREAM_COUNT-1:0] m_valid_o,
    input  logic [STREAM_COUNT-1:0] m_ready_i,
    output logic                    drop_o,
    output logic                    id_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        DROP
    } state_t;

    state_t                  state_q, state_d;
    logic [T_ID_WIDTH-1:0]   dst_q, dst_d;
    logic                    drop_q, drop_d;
    logic                    id_err_q, id_err_d;

    logic [T_DATA_WIDTH-1:0] data_q [STREAM_COUNT];
    logic [T_DATA_WIDTH-1:0] data_d [STREAM_COUNT];
    logic [T_QOS_WIDTH-1:0]  qos_q  [STREAM_COUNT];
    logic [T_QOS_WIDTH-1:0]  qos_d  [STREAM_COUNT];
    logic [STREAM_COUNT-1:0] last_q, last_d;
    logic [STREAM_COUNT-1:0] valid_q, valid_d;

    logic [STREAM_COUNT-1:0] slot_free;
    logic [STREAM_COUNT-1:0] wr_en;
    logic [T_ID_WIDTH-1:0]   sel_idx;
    logic                    sel_free;
    logic                    id_legal;
    logic                    wr_sel;

    // A slot can take a new beat when empty or when it drains this cycle.
    assign slot_free = ~valid_q | m_ready_i;

    // The slot of interest is the incoming id while idle, else the locked one.
    // Selection is done by comparison so an out-of-range id never indexes
    // past the end of the slot arrays.
    always_comb begin
        sel_idx  = (state_q == IDLE) ? s_id_i : dst_q;
        sel_free = 1'b0;
        for (int unsigned n = 0; n < STREAM_COUNT; n++) begin
            if (32'(sel_idx) == n) begin
                sel_free = slot_free[n];
            end
        end
        id_legal = (32'(s_id_i) < 32'(STREAM_COUNT));
    end

    // Controller: next state, handshake and event pulses.
    always_comb begin
        state_d   = state_q;
        dst_d     = dst_q;
        drop_d    = 1'b0;
        id_err_d  = 1'b0;
        wr_sel    = 1'b0;
        s_ready_o = 1'b0;

        case (state_q)
            IDLE: begin
                s_ready_o = id_legal ? sel_free : 1'b1;
                if (s_valid_i && s_ready_o) begin
                    if (id_legal) begin
                        wr_sel = 1'b1;
                        dst_d  = s_id_i;
                        if (!s_last_i) begin
                            state_d = ROUTE;
                        end
                    end else if (!s_last_i) begin
                        state_d = DROP;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            ROUTE: begin
                s_ready_o = sel_free;
                if (s_valid_i && s_ready_o) begin
                    wr_sel = 1'b1;
                    if (s_id_i != dst_q) begin
                        id_err_d = 1'b1;
                    end
                    if (s_last_i) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                s_ready_o = 1'b1;
                if (s_valid_i && s_last_i) begin
                    state_d = IDLE;
                    drop_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_en = '0;
        for (int unsigned n = 0; n < STREAM_COUNT; n++) begin
            if (32'(sel_idx) == n) begin
                wr_en[n] = wr_sel;
            end
        end
    end

    // Output slots: a write wins over a drain, so a simultaneous write and
    // drain keeps the slot valid with the new contents.
    always_comb begin
        for (int unsigned n = 0; n < STREAM_COUNT; n++) begin
            data_d[n]  = data_q[n];
            qos_d[n]   = qos_q[n];
            last_d[n]  = last_q[n];
            valid_d[n] = valid_q[n];
            if (wr_en[n]) begin
                data_d[n]  = s_data_i;
                qos_d[n]   = s_qos_i;
                last_d[n]  = s_last_i;
                valid_d[n] = 1'b1;
            end else if (valid_q[n] && m_ready_i[n]) begin
                valid_d[n] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dst_q    <= '0;
            drop_q   <= 1'b0;
            id_err_q <= 1'b0;
            last_q   <= '0;
            valid_q  <= '0;
            for (int unsigned n = 0; n < STREAM_COUNT; n++) begin
                data_q[n] <= '0;
                qos_q[n]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            dst_q    <= dst_d;
            drop_q   <= drop_d;
            id_err_q <= id_err_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            for (int unsigned n = 0; n < STREAM_COUNT; n++) begin
                data_q[n] <= data_d[n];
                qos_q[n]  <= qos_d[n];
            end
        end
    end

    assign m_data_o  = data_q;
    assign m_qos_o   = qos_q;
    assign m_last_o  = last_q;
    assign m_valid_o = valid_q;
    assign drop_o    = drop_q;
    assign id_err_o  = id_err_q;

endmodule
